// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator: shared prescaler and period counter, N_CH compare channels with polarity.
// Optional macro PWM_SHADOW_EN double-buffers period/compare/polarity so they change only at period wrap.
module pwm_gen_multi #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 8,
    parameter int PRE_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [PRE_W-1:0]      prescale_i,
    input  logic [CNT_W-1:0]      period_i,
    input  logic [N_CH*CNT_W-1:0] comp_i,
    input  logic [N_CH-1:0]       pol_i,
    output logic [N_CH-1:0]       pwm_o,
    output logic                  cycle_o,
    output logic [CNT_W-1:0]      cnt_o
);

    logic [PRE_W-1:0] pre_cnt_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [N_CH-1:0]  pwm_reg;
    logic [N_CH-1:0]  pwm_next;
    logic             cycle_reg;
    logic             tick;
    logic             wrap;

    logic [CNT_W-1:0] period_eff;
    logic [CNT_W-1:0] comp_eff [N_CH];
    logic [N_CH-1:0]  pol_eff;

`ifdef PWM_SHADOW_EN
    logic [CNT_W-1:0] period_sh_reg;
    logic [CNT_W-1:0] comp_sh_reg [N_CH];
    logic [N_CH-1:0]  pol_sh_reg;
    logic             load_sh;

    // While stopped the shadows track the inputs so a restart begins with current settings.
    assign load_sh = !en_i || (tick && wrap);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_sh_reg <= '0;
            pol_sh_reg    <= '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                comp_sh_reg[ch] <= '0;
            end
        end else if (load_sh) begin
            period_sh_reg <= period_i;
            pol_sh_reg    <= pol_i;
            for (int ch = 0; ch < N_CH; ch++) begin
                comp_sh_reg[ch] <= comp_i[ch*CNT_W +: CNT_W];
            end
        end
    end

    assign period_eff = period_sh_reg;
    assign pol_eff    = pol_sh_reg;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_comp_sh
        assign comp_eff[gi] = comp_sh_reg[gi];
    end
`else
    assign period_eff = period_i;
    assign pol_eff    = pol_i;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_comp_direct
        assign comp_eff[gi] = comp_i[gi*CNT_W +: CNT_W];
    end
`endif

    // >= so that lowering prescale/period below the running count forces an immediate tick/wrap.
    assign tick = (pre_cnt_reg >= prescale_i);
    assign wrap = (cnt_reg >= period_eff);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_cmp
        assign pwm_next[gi] = (cnt_reg < comp_eff[gi]) ^ pol_eff[gi];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_cnt_reg <= '0;
            cnt_reg     <= '0;
            cycle_reg   <= 1'b0;
        end else if (!en_i) begin
            pre_cnt_reg <= '0;
            cnt_reg     <= '0;
            cycle_reg   <= 1'b0;
        end else begin
            cycle_reg <= 1'b0;
            if (tick) begin
                pre_cnt_reg <= '0;
                if (wrap) begin
                    cnt_reg   <= '0;
                    cycle_reg <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end else begin
                pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pwm_reg <= '0;
        end else if (!en_i) begin
            pwm_reg <= pol_i;
        end else begin
            pwm_reg <= pwm_next;
        end
    end

    assign pwm_o   = pwm_reg;
    assign cycle_o = cycle_reg;
    assign cnt_o   = cnt_reg;

endmodule
